change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 26 ++
 rtl/change_dispenser_coin_select.sv | 38 +++
 rtl/change_dispenser.sv | 118 +++++++++++
 3 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin encodings, denomination
// values in cents and the controller state type.
package change_dispenser_pkg;

  localparam logic [2:0] COIN_NONE    = 3'd0;
  localparam logic [2:0] COIN_PENNY   = 3'd1;
  localparam logic [2:0] COIN_NICKEL  = 3'd2;
  localparam logic [2:0] COIN_DIME    = 3'd3;
  localparam logic [2:0] COIN_QUARTER = 3'd4;
  localparam logic [2:0] COIN_DOLLAR  = 3'd5;

  localparam int unsigned VAL_PENNY   = 32'd1;
  localparam int unsigned VAL_NICKEL  = 32'd5;
  localparam int unsigned VAL_DIME    = 32'd10;
  localparam int unsigned VAL_QUARTER = 32'd25;
  localparam int unsigned VAL_DOLLAR  = 32'd100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CALC     = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: the largest denomination not exceeding the amount
// still owed, with its code and value. Purely combinational.
module coin_select
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] remaining,
  output logic [2:0]       code,
  output logic [WIDTH-1:0] value
);

  // pick the largest coin that fits; nothing when no change is owed
  always_comb begin
    code  = COIN_NONE;
    value = {WIDTH{1'b0}};
    if (remaining >= WIDTH'(VAL_DOLLAR)) begin
      code  = COIN_DOLLAR;
      value = WIDTH'(VAL_DOLLAR);
    end else if (remaining >= WIDTH'(VAL_QUARTER)) begin
      code  = COIN_QUARTER;
      value = WIDTH'(VAL_QUARTER);
    end else if (remaining >= WIDTH'(VAL_DIME)) begin
      code  = COIN_DIME;
      value = WIDTH'(VAL_DIME);
    end else if (remaining >= WIDTH'(VAL_NICKEL)) begin
      code  = COIN_NICKEL;
      value = WIDTH'(VAL_NICKEL);
    end else if (remaining >= WIDTH'(VAL_PENNY)) begin
      code  = COIN_PENNY;
      value = WIDTH'(VAL_PENNY);
    end else begin
      code  = COIN_NONE;
      value = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller: checks money against price, then hands out
// change one coin per accepted handshake using greedy denomination choice.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] money,
  input  logic [WIDTH-1:0] price,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [2:0]       coin_code,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] remaining
);

  state_t           state_r;
  logic [WIDTH-1:0] money_r;
  logic [WIDTH-1:0] price_r;
  logic [WIDTH-1:0] remaining_r;
  logic             coin_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic [2:0]       sel_code_s;
  logic [WIDTH-1:0] sel_value_s;
  logic [WIDTH-1:0] rem_next_s;

  coin_select #(.WIDTH(WIDTH)) u_coin_select (
    .remaining (remaining_r),
    .code      (sel_code_s),
    .value     (sel_value_s)
  );

  // remaining after the presented coin transfers; never underflows since
  // the selected coin is always <= remaining_r
  assign rem_next_s = remaining_r - sel_value_s;

  // controller state and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      money_r      <= {WIDTH{1'b0}};
      price_r      <= {WIDTH{1'b0}};
      remaining_r  <= {WIDTH{1'b0}};
      coin_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            money_r <= money;
            price_r <= price;
            busy_r  <= 1'b1;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (money_r < price_r) begin
            remaining_r <= {WIDTH{1'b0}};
            error_r     <= 1'b1;
            state_r     <= ST_ERR;
          end else if (money_r == price_r) begin
            remaining_r <= {WIDTH{1'b0}};
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            remaining_r  <= money_r - price_r;
            coin_valid_r <= 1'b1;
            state_r      <= ST_DISPENSE;
          end
        end
        ST_DISPENSE: begin
          if (coin_ready) begin
            remaining_r <= rem_next_s;
            if (rem_next_s == {WIDTH{1'b0}}) begin
              coin_valid_r <= 1'b0;
              done_r       <= 1'b1;
              state_r      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          error_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          coin_valid_r <= 1'b0;
          done_r       <= 1'b0;
          error_r      <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign coin_valid = coin_valid_r;
  assign coin_code  = coin_valid_r ? sel_code_s : COIN_NONE;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign remaining  = remaining_r;

endmodule
